// File: rtl/nmea_sentence_arbiter.sv
// ---------------------------------------------------------------------------
// nmea_sentence_arbiter
//
// Purpose:
//   Shares one downstream sentence consumer among NCH NMEA receiver channels.
//   Receivers raise a level request when a sentence is complete. The arbiter
//   grants one channel at a time in round-robin order. It latches that
//   channel's talker id, sentence id, checksum flag and index. It then
//   presents them on a valid/ready handshake. It also keeps saturating counts
//   of forwarded and dropped sentences.
//
// Optional feature (macro CHK_FILTER_EN):
//   When defined, a granted sentence that failed its checksum is acked and
//   counted as dropped, but it is never presented downstream.
//
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-low reset
//   i_req       per-channel sentence-ready request (level, held until acked)
//   i_tid       talker ids, channel k at [16k+15:16k]
//   i_sid       sentence ids, channel k at [24k+23:24k]
//   i_ok        per-channel checksum-pass flags
//   o_ack       one-cycle pulse to the channel whose sentence is captured;
//               it is driven in the grant cycle itself
//   o_valid     downstream sentence valid
//   i_ready     downstream accept
//   o_ch        source channel of the presented sentence
//   o_tid       latched talker id
//   o_sid       latched sentence id
//   o_ok        latched checksum flag
//   o_fwd_cnt   sentences accepted downstream (saturating)
//   o_drop_cnt  sentences dropped by timeout, plus filtered ones when
//               CHK_FILTER_EN is defined (saturating)
// ---------------------------------------------------------------------------
module nmea_sentence_arbiter #(
  parameter int NCH     = 2,
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NCH-1:0]           i_req,
  input  logic [16*NCH-1:0]        i_tid,
  input  logic [24*NCH-1:0]        i_sid,
  input  logic [NCH-1:0]           i_ok,
  output logic [NCH-1:0]           o_ack,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(NCH)-1:0]   o_ch,
  output logic [15:0]              o_tid,
  output logic [23:0]              o_sid,
  output logic                     o_ok,
  output logic [CNTW-1:0]          o_fwd_cnt,
  output logic [CNTW-1:0]          o_drop_cnt
);

  localparam int CHW = $clog2(NCH);
  localparam int WW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e          state_q, state_d;
  logic [CHW-1:0]  rr_q, rr_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [15:0]     tid_q, tid_d;
  logic [23:0]     sid_q, sid_d;
  logic            ok_q, ok_d;
  logic [CNTW-1:0] fwd_q, fwd_d;
  logic [CNTW-1:0] drop_q, drop_d;

  logic            grantFound;
  logic [CHW-1:0]  grantIdx;
  logic [15:0]     selTid;
  logic [23:0]     selSid;
  logic            selOk;
  logic [NCH-1:0]  ackVec;
  logic            timeoutHit;

  function automatic logic [CNTW-1:0] satInc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // Round-robin search: walk the channels starting at the rr pointer and
  // wrap modulo NCH. The first requesting channel wins. NCH need not be a
  // power of two, so the wrap is done arithmetically, not by bit overflow.
  always_comb begin
    int cand;
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = 0;
    for (int k = 0; k < NCH; k++) begin
      cand = (int'(rr_q) + k) % NCH;
      if (!grantFound && i_req[cand]) begin
        grantFound = 1'b1;
        grantIdx   = CHW'(cand);
      end
    end
  end

  // Fields of the winning channel, ready to be latched in the grant cycle.
  always_comb begin
    selTid = i_tid[16*grantIdx +: 16];
    selSid = i_sid[24*grantIdx +: 24];
    selOk  = i_ok[grantIdx];
  end

  // The wait counter ends a presentation when it reaches its last value
  // without a ready. A TIMEOUT of zero turns this check off entirely.
  always_comb begin
    timeoutHit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);
  end

  // Next-state logic. In IDLE a grant latches the sentence and acks the
  // channel in the same cycle. o_valid is the SEND state itself, so it
  // rises one cycle later. In SEND, a ready in the timeout cycle still
  // forwards the sentence, because ready is tested first.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    wait_d  = wait_q;
    ch_d    = ch_q;
    tid_d   = tid_q;
    sid_d   = sid_q;
    ok_d    = ok_q;
    fwd_d   = fwd_q;
    drop_d  = drop_q;
    ackVec  = '0;
    case (state_q)
      IDLE: begin
        if (grantFound) begin
          ackVec[grantIdx] = 1'b1;
          rr_d = (int'(grantIdx) == NCH - 1) ? '0 : grantIdx + 1'b1;
`ifdef CHK_FILTER_EN
          if (!selOk) begin
            drop_d = satInc(drop_q);
          end else begin
            ch_d    = grantIdx;
            tid_d   = selTid;
            sid_d   = selSid;
            ok_d    = selOk;
            wait_d  = '0;
            state_d = SEND;
          end
`else
          ch_d    = grantIdx;
          tid_d   = selTid;
          sid_d   = selSid;
          ok_d    = selOk;
          wait_d  = '0;
          state_d = SEND;
`endif
        end
      end
      SEND: begin
        if (i_ready) begin
          fwd_d   = satInc(fwd_q);
          wait_d  = '0;
          state_d = IDLE;
        end else if (timeoutHit) begin
          drop_d  = satInc(drop_q);
          wait_d  = '0;
          state_d = IDLE;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. An asynchronous reset discards any sentence
  // in flight. Channels simply request again after the reset is released.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      wait_q  <= '0;
      ch_q    <= '0;
      tid_q   <= '0;
      sid_q   <= '0;
      ok_q    <= 1'b0;
      fwd_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wait_q  <= wait_d;
      ch_q    <= ch_d;
      tid_q   <= tid_d;
      sid_q   <= sid_d;
      ok_q    <= ok_d;
      fwd_q   <= fwd_d;
      drop_q  <= drop_d;
    end
  end

  // The ack comes straight from the grant decision. It is masked while
  // reset is asserted, because a channel could be requesting during reset
  // and must not be told that its sentence was taken.
  always_comb begin
    o_ack      = ackVec & {NCH{i_rst}};
    o_valid    = (state_q == SEND);
    o_ch       = ch_q;
    o_tid      = tid_q;
    o_sid      = sid_q;
    o_ok       = ok_q;
    o_fwd_cnt  = fwd_q;
    o_drop_cnt = drop_q;
  end

endmodule

// File: tb/tb_nmea_sentence_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nmea_sentence_arbiter
//
// Drives two arbiters from the same inputs:
//   dutA uses the defaults (TIMEOUT=1024, CNTW=16).
//   dutB uses a short timeout and narrow counters (TIMEOUT=8, CNTW=2), so
//   that both the drop path and counter saturation are reachable.
// A transaction-level model of each arbiter is stepped on every clock. One
// compare process checks both DUTs against it on each falling edge. Directed
// tests then pin the model with hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_nmea_sentence_arbiter;

  localparam int NCH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   req = '0;
  logic [16*NCH-1:0] tid = '0;
  logic [24*NCH-1:0] sid = '0;
  logic [NCH-1:0]   ok = '0;
  logic             ready = 1'b0;

  logic [NCH-1:0] ackA, ackB;
  logic           validA, validB;
  logic           chA, chB;
  logic [15:0]    tidA, tidB;
  logic [23:0]    sidA, sidB;
  logic           okA, okB;
  logic [15:0]    fwdA, dropA;
  logic [1:0]     fwdB, dropB;

  int checks = 0;
  int errors = 0;

  int orderQ[$];
  int validCntA = 0;
  int validCntB = 0;
  logic lastOkA = 1'b1;

  always #5 clk = ~clk;

  nmea_sentence_arbiter #(.NCH(NCH), .TIMEOUT(1024), .CNTW(16)) dutA (
    .i_clk(clk), .i_rst(rst_n), .i_req(req), .i_tid(tid), .i_sid(sid),
    .i_ok(ok), .o_ack(ackA), .o_valid(validA), .i_ready(ready), .o_ch(chA),
    .o_tid(tidA), .o_sid(sidA), .o_ok(okA), .o_fwd_cnt(fwdA),
    .o_drop_cnt(dropA)
  );

  nmea_sentence_arbiter #(.NCH(NCH), .TIMEOUT(8), .CNTW(2)) dutB (
    .i_clk(clk), .i_rst(rst_n), .i_req(req), .i_tid(tid), .i_sid(sid),
    .i_ok(ok), .o_ack(ackB), .o_valid(validB), .i_ready(ready), .o_ch(chB),
    .o_tid(tidB), .o_sid(sidB), .o_ok(okB), .o_fwd_cnt(fwdB),
    .o_drop_cnt(dropB)
  );

  // Transaction-level view of one arbiter: what is being presented, how
  // long it has waited, whose turn is next, and the statistics counts.
  typedef struct {
    bit        busy;
    int        waitCnt;
    int        ch;
    bit [15:0] tid;
    bit [23:0] sid;
    bit        ok;
    int        rr;
    int        fwd;
    int        drop;
  } model_t;

  model_t mA, mB;

  function automatic model_t resetModel();
    model_t m;
    m.busy = 0; m.waitCnt = 0; m.ch = 0; m.tid = 0; m.sid = 0;
    m.ok = 0; m.rr = 0; m.fwd = 0; m.drop = 0;
    return m;
  endfunction

  function automatic int pickChannel(input model_t m, input logic [NCH-1:0] r);
    for (int k = 0; k < NCH; k++) begin
      if (r[(m.rr + k) % NCH]) return (m.rr + k) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] expectAck(input model_t m,
                                               input logic [NCH-1:0] r);
    logic [NCH-1:0] a;
    int g;
    a = '0;
    if (!m.busy) begin
      g = pickChannel(m, r);
      if (g >= 0) a[g] = 1'b1;
    end
    return a;
  endfunction

  function automatic model_t stepModel(input model_t m,
                                       input logic [NCH-1:0] r,
                                       input logic [16*NCH-1:0] t,
                                       input logic [24*NCH-1:0] s,
                                       input logic [NCH-1:0] o,
                                       input logic rdy,
                                       input int timeout,
                                       input int maxCnt);
    model_t n;
    int g;
    n = m;
    if (m.busy) begin
      if (rdy) begin
        n.busy = 0; n.waitCnt = 0;
        n.fwd = (m.fwd < maxCnt) ? m.fwd + 1 : maxCnt;
      end else if (timeout != 0 && m.waitCnt == timeout - 1) begin
        n.busy = 0; n.waitCnt = 0;
        n.drop = (m.drop < maxCnt) ? m.drop + 1 : maxCnt;
      end else begin
        n.waitCnt = m.waitCnt + 1;
      end
    end else begin
      g = pickChannel(m, r);
      if (g >= 0) begin
        n.rr = (g + 1) % NCH;
`ifdef CHK_FILTER_EN
        if (!o[g]) begin
          n.drop = (m.drop < maxCnt) ? m.drop + 1 : maxCnt;
          return n;
        end
`endif
        n.busy = 1; n.waitCnt = 0; n.ch = g;
        n.tid = t[16*g +: 16];
        n.sid = s[24*g +: 24];
        n.ok = o[g];
      end
    end
    return n;
  endfunction

  // Advance both models on every clock edge. Reset clears them at once,
  // just as it clears the hardware.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mA <= resetModel();
      mB <= resetModel();
    end else begin
      mA <= stepModel(mA, req, tid, sid, ok, ready, 1024, 65535);
      mB <= stepModel(mB, req, tid, sid, ok, ready, 8, 3);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Compare both DUTs against their models on each falling edge. This
  // process also records grant order, valid lengths and the presented ok
  // flag, which the directed tests check afterwards.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("A.ack",   ackA,   expectAck(mA, req));
      checkOutput("A.valid", validA, mA.busy);
      checkOutput("A.ch",    chA,    mA.ch);
      checkOutput("A.tid",   tidA,   mA.tid);
      checkOutput("A.sid",   sidA,   mA.sid);
      checkOutput("A.ok",    okA,    mA.ok);
      checkOutput("A.fwd",   fwdA,   mA.fwd);
      checkOutput("A.drop",  dropA,  mA.drop);
      checkOutput("B.ack",   ackB,   expectAck(mB, req));
      checkOutput("B.valid", validB, mB.busy);
      checkOutput("B.ch",    chB,    mB.ch);
      checkOutput("B.tid",   tidB,   mB.tid);
      checkOutput("B.sid",   sidB,   mB.sid);
      checkOutput("B.ok",    okB,    mB.ok);
      checkOutput("B.fwd",   fwdB,   mB.fwd);
      checkOutput("B.drop",  dropB,  mB.drop);
      if (validA) begin
        validCntA++;
        lastOkA = okA;
        if (ready) orderQ.push_back(int'(chA));
      end
      if (validB) validCntB++;
    end
  end

  task automatic applyStimulus(input logic [NCH-1:0] r, input logic rdy,
                               input int cycles);
    req = r;
    ready = rdy;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    validCntA = 0;
    validCntB = 0;
    lastOkA = 1'b1;
    orderQ.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tid = {16'h4C4E, 16'h4750};
    sid = {24'h524D43, 24'h474741};
    ok = 2'b11;
    ready = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    req = 2'b11;
    #1;
    checkOutput("rst.ack",   ackA,   2'b00);
    checkOutput("rst.valid", validA, 1'b0);
    checkOutput("rst.ch",    chA,    1'b0);
    checkOutput("rst.tid",   tidA,   16'h0);
    checkOutput("rst.fwd",   fwdA,   16'd0);
    checkOutput("rst.drop",  dropA,  16'd0);
    doReset();

    $display("[TB] single channel");
    req = 2'b01;
    ready = 1'b1;
    #1;
    checkOutput("single.ack", ackA, 2'b01);
    @(posedge clk);
    #1;
    req = 2'b00;
    checkOutput("single.valid", validA, 1'b1);
    checkOutput("single.ch",    chA,    1'b0);
    checkOutput("single.tid",   tidA,   16'h4750);
    checkOutput("single.sid",   sidA,   24'h474741);
    checkOutput("single.ok",    okA,    1'b1);
    applyStimulus(2'b00, 1'b1, 2);
    checkOutput("single.validLen", validCntA, 1);
    checkOutput("single.fwd",      fwdA,      16'd1);

    $display("[TB] round robin");
    doReset();
    applyStimulus(2'b11, 1'b1, 11);
    applyStimulus(2'b00, 1'b1, 3);
    checkOutput("rr.count", orderQ.size(), 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("rr.order%0d", i),
                  (i < orderQ.size()) ? orderQ[i] : 99, i % 2);
    end
    checkOutput("rr.fwdA", fwdA, 16'd6);
    checkOutput("rr.fwdB", fwdB, 2'd3);

    $display("[TB] backpressure");
    doReset();
    applyStimulus(2'b01, 1'b0, 1);
    applyStimulus(2'b00, 1'b0, 10);
    applyStimulus(2'b00, 1'b1, 3);
    checkOutput("bp.validLenA", validCntA, 11);
    checkOutput("bp.fwdA",      fwdA,      16'd1);
    checkOutput("bp.dropA",     dropA,     16'd0);
    checkOutput("to.validLenB", validCntB, 8);
    checkOutput("to.fwdB",      fwdB,      2'd0);
    checkOutput("to.dropB",     dropB,     2'd1);

    $display("[TB] ready in timeout cycle");
    doReset();
    applyStimulus(2'b10, 1'b0, 1);
    applyStimulus(2'b00, 1'b0, 7);
    applyStimulus(2'b00, 1'b1, 3);
    checkOutput("toRdy.validLenB", validCntB, 8);
    checkOutput("toRdy.fwdB",      fwdB,      2'd1);
    checkOutput("toRdy.dropB",     dropB,     2'd0);

    $display("[TB] bad checksum");
    doReset();
    ok = 2'b01;
    req = 2'b10;
    ready = 1'b1;
    #1;
    checkOutput("bad.ack", ackA, 2'b10);
    @(posedge clk);
    #1;
    applyStimulus(2'b00, 1'b1, 3);
`ifdef CHK_FILTER_EN
    checkOutput("bad.validLen", validCntA, 0);
    checkOutput("bad.drop",     dropA,     16'd1);
    checkOutput("bad.fwd",      fwdA,      16'd0);
`else
    checkOutput("bad.validLen", validCntA, 1);
    checkOutput("bad.okSeen",   lastOkA,   1'b0);
    checkOutput("bad.fwd",      fwdA,      16'd1);
    checkOutput("bad.drop",     dropA,     16'd0);
`endif
    ok = 2'b11;

    $display("[TB] reset during send");
    doReset();
    applyStimulus(2'b10, 1'b1, 1);
    applyStimulus(2'b00, 1'b1, 1);
    applyStimulus(2'b10, 1'b0, 1);
    applyStimulus(2'b00, 1'b0, 3);
    checkOutput("midRst.validBefore", validA, 1'b1);
    checkOutput("midRst.chBefore",    chA,    1'b1);
    checkOutput("midRst.fwdBefore",   fwdA,   16'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRst.valid", validA, 1'b0);
    checkOutput("midRst.ch",    chA,    1'b0);
    checkOutput("midRst.fwd",   fwdA,   16'd0);
    checkOutput("midRst.drop",  dropA,  16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 2'b11;
    ready = 1'b1;
    #1;
    checkOutput("postRst.ack", ackA, 2'b01);
    @(posedge clk);
    #1;
    req = 2'b00;
    checkOutput("postRst.valid", validA, 1'b1);
    checkOutput("postRst.ch",    chA,    1'b0);
    applyStimulus(2'b00, 1'b1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
